spi_slave_sync_core: RTL and testbench

- SPI slave (CPOL=0, CPHA=0, MSB first, 8-bit default) whose SPI inputs are asynchronous to the local system clock.
- sclk, ss and mosi are synchronised into the clk domain; edges are detected there, and all state is clocked by clk.
- Delivers each received master byte on mdat with a ready flag, and shifts the slave byte sdat out on miso.
- Sits between an off-chip SPI master and local register/FIFO logic.

---
 rtl/spi_slave_sync_core.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_sync_core.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync_core.sv
// CPOL=0/CPHA=0 SPI slave with SPI pins synchronised into the clk domain.
// Build option: define MISO_TRISTATE_EN to float miso while the slave is IDLE.
module spi_slave_sync_core #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ss,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [0:WIDTH-1] sdat,
  output logic [WIDTH-1:0] mdat,
  output logic             ready
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   sclk_rise, sclk_fall;

  logic [WIDTH-1:0] rx_q, rx_d;
  logic [0:WIDTH-1] tx_q, tx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mdat_q, mdat_d;
  logic             ready_q, ready_d;
  logic             miso_q, miso_d;

  // mosi shares sclk's synchroniser depth so a detected rise samples the bit
  // that was stable at the physical edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    if (!ss_s) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_d = LOAD;
        LOAD:    state_d = SHIFT;
        SHIFT:   if (sclk_rise && cnt_q == CW'(WIDTH - 1)) state_d = DONE;
        DONE:    if (sclk_fall) state_d = SHIFT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Deselect overrides any sclk edge seen in the same cycle; mdat is kept.
  always_comb begin
    rx_d    = rx_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    mdat_d  = mdat_q;
    ready_d = ready_q;
    miso_d  = miso_q;
    if (!ss_s) begin
      rx_d    = '0;
      cnt_d   = '0;
      ready_d = 1'b0;
      miso_d  = 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          tx_d    = sdat;
          miso_d  = sdat[0];
          cnt_d   = '0;
          ready_d = 1'b0;
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_d  = {rx_q[WIDTH-2:0], mosi_s};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              mdat_d  = {rx_q[WIDTH-2:0], mosi_s};
              ready_d = 1'b1;
            end
          end else if (sclk_fall && cnt_q != '0) begin
            tx_d   = {tx_q[1:WIDTH-1], 1'b0};
            miso_d = tx_q[1];
          end
        end
        DONE: begin
          if (sclk_fall) begin
            ready_d = 1'b0;
            tx_d    = sdat;
            miso_d  = sdat[0];
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q    <= '0;
      tx_q    <= '0;
      cnt_q   <= '0;
      mdat_q  <= '0;
      ready_q <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      mdat_q  <= mdat_d;
      ready_q <= ready_d;
      miso_q  <= miso_d;
    end
  end

  assign mdat  = mdat_q;
  assign ready = ready_q;

`ifdef MISO_TRISTATE_EN
  assign miso = (state == IDLE) ? 1'bz : miso_q;
`else
  assign miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync_core.sv
// Directed bench for spi_slave_sync_core: word stream table plus abort/reset sequences.
module tb_spi_slave_sync_core;

  logic       clk;
  logic       rst_n;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [0:7] sdat;
  logic [7:0] mdat;
  logic       ready;

  int unsigned errors = 0;
  int unsigned checks = 0;

`ifdef MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  spi_slave_sync_core #(
    .WIDTH      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ss   (ss),
    .sclk (sclk),
    .mosi (mosi),
    .miso (miso),
    .sdat (sdat),
    .mdat (mdat),
    .ready(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] mtx;
    logic [7:0] sdat;
    bit         chk_miso;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side: one sclk period is 10 clk; returns with sclk high after the last rise.
  task automatic shift_bits(input logic [7:0] m, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      mosi = m[i];
      wait_clks(5);
      sclk = 1'b1;
      r = {r[6:0], miso};
      if (i != 0) begin
        wait_clks(5);
        sclk = 1'b0;
      end
    end
    wait_clks(4);
  endtask

  logic [7:0] rx_byte;
  logic [7:0] nxt;

  initial begin
    vecs[0] = '{mtx: 8'hff, sdat: 8'hxx, chk_miso: 1'b0};
    vecs[1] = '{mtx: 8'h00, sdat: 8'h00, chk_miso: 1'b1};
    vecs[2] = '{mtx: 8'ha2, sdat: 8'h71, chk_miso: 1'b1};
    vecs[3] = '{mtx: 8'h41, sdat: 8'h32, chk_miso: 1'b1};
    vecs[4] = '{mtx: 8'hc3, sdat: 8'ha5, chk_miso: 1'b1};

    rst_n = 1'b0; ss = 1'b0; sclk = 1'b0; mosi = 1'b0; sdat = '0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2);
    chk("reset_state", 32'(dut.state), 32'd0);
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_mdat", {24'b0, mdat}, 32'd0);
    chk("reset_miso", {31'b0, miso}, {31'b0, MISO_IDLE});

    sclk = 1'b1; wait_clks(5); sclk = 1'b0; wait_clks(5);
    chk("unselected_state", 32'(dut.state), 32'd0);
    chk("unselected_ready", {31'b0, ready}, 32'd0);

    // Abort: partial word must never be reported
    ss = 1'b1; wait_clks(5);
    sclk = 1'b1; wait_clks(5); sclk = 1'b0; wait_clks(5); sclk = 1'b1; wait_clks(5);
    chk("abort_shift_state", 32'(dut.state), 32'd3);
    ss = 1'b0; wait_clks(3);
    chk("abort_state", 32'(dut.state), 32'd0);
    chk("abort_ready", {31'b0, ready}, 32'd0);
    chk("abort_mdat", {24'b0, mdat}, 32'd0);
    chk("abort_miso", {31'b0, miso}, {31'b0, MISO_IDLE});
    sclk = 1'b0; wait_clks(5);

    // Continuous stream with ss held high
    sdat = vecs[0].sdat;
    ss = 1'b1; wait_clks(10);
    for (int k = 0; k < 5; k++) begin
      shift_bits(vecs[k].mtx, rx_byte);
      chk($sformatf("w%0d_ready_hi", k), {31'b0, ready}, 32'd1);
      chk($sformatf("w%0d_mdat", k), {24'b0, mdat}, {24'b0, vecs[k].mtx});
      if (vecs[k].chk_miso)
        chk($sformatf("w%0d_miso_rx", k), {24'b0, rx_byte}, {24'b0, vecs[k].sdat});
      nxt = (k < 4) ? vecs[k+1].sdat : 8'h00;
      sdat = nxt;
      wait_clks(1);
      sclk = 1'b0;
      wait_clks(4);
      chk($sformatf("w%0d_ready_lo", k), {31'b0, ready}, 32'd0);
      chk($sformatf("w%0d_mdat_hold", k), {24'b0, mdat}, {24'b0, vecs[k].mtx});
      sdat = ~nxt;
    end
    ss = 1'b0; wait_clks(5);
    chk("deselect_mdat_kept", {24'b0, mdat}, 32'h00c3);
    chk("deselect_state", 32'(dut.state), 32'd0);

    // Reset in the middle of bit 4
    ss = 1'b1; wait_clks(10);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1; wait_clks(5); sclk = 1'b1; wait_clks(5); sclk = 1'b0;
    end
    mosi = 1'b0; wait_clks(5); sclk = 1'b1; wait_clks(2);
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_mdat", {24'b0, mdat}, 32'd0);
    chk("rst_miso", {31'b0, miso}, {31'b0, MISO_IDLE});
    sclk = 1'b0; ss = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);
    chk("post_rst_idle", 32'(dut.state), 32'd0);

    sdat = 8'hc6;
    ss = 1'b1;
    wait_clks(2);
    chk("pre_load_miso", {31'b0, miso}, {31'b0, MISO_IDLE});
    wait_clks(1);
    chk("load_state", 32'(dut.state), 32'd1);
    wait_clks(1);
    chk("load_miso", {31'b0, miso}, 32'd1);
    chk("load_to_shift", 32'(dut.state), 32'd3);
    wait_clks(6);
    shift_bits(8'h5a, rx_byte);
    chk("rst_word_ready", {31'b0, ready}, 32'd1);
    chk("rst_word_mdat", {24'b0, mdat}, 32'h005a);
    chk("rst_word_miso_rx", {24'b0, rx_byte}, 32'h00c6);
    sclk = 1'b0; wait_clks(5);
    ss = 1'b0; wait_clks(5);
    chk("final_ready", {31'b0, ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
